// File: rtl/ball_motion.sv
// Ball stage: owns ball position, direction and the serve/lost/game-over sequence,
// and paints the square ball into the VGA colour stream.
module ball_motion #(
    parameter int BALL_SIZE  = 8,
    parameter int TICK_DIV   = 208333,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int LIVES_INIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        launch,
    input  logic [9:0]  paddle_x,
    input  logic [9:0]  paddle_y,
    input  logic [9:0]  paddle_width,
    input  logic [9:0]  paddle_height,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        active_pixels,
    output logic [23:0] vga_color,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [1:0]  lives,
    output logic        ball_lost,
    output logic        game_over
);

    localparam logic [10:0] SIZE_W    = 11'(BALL_SIZE);
    localparam logic [10:0] HALF_W    = 11'(BALL_SIZE / 2);
    localparam logic [10:0] SCR_W     = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H     = 11'(SCREEN_H);
    localparam logic [19:0] TICK_LAST = 20'(TICK_DIV);
    localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);
    localparam logic [23:0] BALL_RGB  = 24'hFF0000;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        LOST  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [19:0] tick_cnt_r;
    logic        tick_s;
    logic [9:0]  ball_x_r;
    logic [9:0]  ball_y_r;
    logic [9:0]  ball_x_nxt_s;
    logic [9:0]  ball_y_nxt_s;
    logic        dx_neg_r;
    logic        dx_neg_nxt_s;
    logic        dy_up_r;
    logic        dy_up_nxt_s;
    logic        armed_r;
    logic        armed_nxt_s;
    logic [1:0]  lives_r;
    logic [1:0]  lives_nxt_s;
    logic        ball_lost_r;
    logic        ball_lost_nxt_s;
    logic        game_over_r;
    logic        game_over_nxt_s;

    logic [10:0] bx_w_s;
    logic [10:0] by_w_s;
    logic [10:0] px_w_s;
    logic [10:0] py_w_s;
    logic [10:0] pix_x_w_s;
    logic [10:0] pix_y_w_s;
    logic [10:0] serve_x_s;
    logic [10:0] serve_y_s;
    logic        hit_left_s;
    logic        hit_right_s;
    logic        hit_top_s;
    logic        hit_paddle_s;
    logic        hit_bottom_s;
    logic        in_ball_s;
    logic        paddle_height_unused_s;

    // Height is reserved for future collision shapes; keep it visibly sunk.
    assign paddle_height_unused_s = |paddle_height;

    // All geometry is widened to 11 bits so edge sums never wrap.
    assign bx_w_s    = {1'b0, ball_x_r};
    assign by_w_s    = {1'b0, ball_y_r};
    assign px_w_s    = {1'b0, paddle_x};
    assign py_w_s    = {1'b0, paddle_y};
    assign pix_x_w_s = {1'b0, x};
    assign pix_y_w_s = {1'b0, y};

    assign serve_x_s = px_w_s + {2'b00, paddle_width[9:1]} - HALF_W;
    assign serve_y_s = py_w_s - SIZE_W;

    assign tick_s       = (tick_cnt_r == TICK_LAST);
    assign hit_left_s   = dx_neg_r && (ball_x_r == 10'd0);
    assign hit_right_s  = !dx_neg_r && ((bx_w_s + SIZE_W) >= SCR_W);
    assign hit_top_s    = dy_up_r && (ball_y_r == 10'd0);
    assign hit_paddle_s = !dy_up_r
                          && ((by_w_s + SIZE_W) == py_w_s)
                          && ((bx_w_s + SIZE_W) > px_w_s)
                          && (bx_w_s < (px_w_s + {1'b0, paddle_width}));
    assign hit_bottom_s = !dy_up_r && ((by_w_s + SIZE_W) >= SCR_H);

    assign in_ball_s = (pix_x_w_s >= bx_w_s) && (pix_x_w_s < (bx_w_s + SIZE_W))
                       && (pix_y_w_s >= by_w_s) && (pix_y_w_s < (by_w_s + SIZE_W));

    // State and datapath registers; reset re-centres the ball on the paddle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= SERVE;
            tick_cnt_r  <= 20'd0;
            ball_x_r    <= serve_x_s[9:0];
            ball_y_r    <= serve_y_s[9:0];
            dx_neg_r    <= 1'b0;
            dy_up_r     <= 1'b1;
            armed_r     <= 1'b0;
            lives_r     <= LIVES_RST;
            ball_lost_r <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            tick_cnt_r  <= tick_s ? 20'd0 : (tick_cnt_r + 20'd1);
            ball_x_r    <= ball_x_nxt_s;
            ball_y_r    <= ball_y_nxt_s;
            dx_neg_r    <= dx_neg_nxt_s;
            dy_up_r     <= dy_up_nxt_s;
            armed_r     <= armed_nxt_s;
            lives_r     <= lives_nxt_s;
            ball_lost_r <= ball_lost_nxt_s;
            game_over_r <= game_over_nxt_s;
        end
    end

    // Next-state and datapath: serve tracking, per-tick motion and life accounting.
    always_comb begin
        state_nxt_s     = state_r;
        ball_x_nxt_s    = ball_x_r;
        ball_y_nxt_s    = ball_y_r;
        dx_neg_nxt_s    = dx_neg_r;
        dy_up_nxt_s     = dy_up_r;
        armed_nxt_s     = armed_r;
        lives_nxt_s     = lives_r;
        ball_lost_nxt_s = 1'b0;
        game_over_nxt_s = game_over_r;
        case (state_r)
            SERVE: begin
                ball_x_nxt_s = serve_x_s[9:0];
                ball_y_nxt_s = serve_y_s[9:0];
                // A launch level still held from before needs a release first.
                if (launch && armed_r) begin
                    state_nxt_s  = MOVE;
                    dx_neg_nxt_s = 1'b0;
                    dy_up_nxt_s  = 1'b1;
                    armed_nxt_s  = 1'b0;
                end else if (!launch) begin
                    armed_nxt_s = 1'b1;
                end else begin
                    armed_nxt_s = armed_r;
                end
            end
            MOVE: begin
                if (tick_s) begin
                    if (hit_left_s) begin
                        dx_neg_nxt_s = 1'b0;
                    end else if (hit_right_s) begin
                        dx_neg_nxt_s = 1'b1;
                    end else if (dx_neg_r) begin
                        ball_x_nxt_s = ball_x_r - 10'd1;
                    end else begin
                        ball_x_nxt_s = ball_x_r + 10'd1;
                    end
                    if (hit_top_s) begin
                        dy_up_nxt_s = 1'b0;
                    end else if (hit_paddle_s) begin
                        dy_up_nxt_s = 1'b1;
                    end else if (hit_bottom_s) begin
                        state_nxt_s     = LOST;
                        ball_lost_nxt_s = 1'b1;
                    end else if (dy_up_r) begin
                        ball_y_nxt_s = ball_y_r - 10'd1;
                    end else begin
                        ball_y_nxt_s = ball_y_r + 10'd1;
                    end
                end else begin
                    state_nxt_s = MOVE;
                end
            end
            LOST: begin
                lives_nxt_s = lives_r - 2'd1;
                if (lives_r == 2'd1) begin
                    state_nxt_s     = OVER;
                    game_over_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            OVER: begin
                game_over_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = SERVE;
            end
        endcase
    end

    // Ball pixel colour for the VGA mux.
    always_comb begin
        vga_color = 24'h000000;
        if (active_pixels && in_ball_s) begin
            vga_color = BALL_RGB;
        end else begin
            vga_color = 24'h000000;
        end
    end

    assign ball_x    = ball_x_r;
    assign ball_y    = ball_y_r;
    assign lives     = lives_r;
    assign ball_lost = ball_lost_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: cycle-level reference model feeding a
// scoreboard queue, plus table vectors and directed multi-cycle sequences.
module tb_ball_motion;

    localparam int TD      = 2;
    localparam int PERIOD  = TD + 1;
    localparam int LONG    = 1000 * PERIOD;
    localparam int M_SERVE = 0;
    localparam int M_MOVE  = 1;
    localparam int M_LOST  = 2;
    localparam int M_OVER  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        launch;
    logic [9:0]  paddle_x;
    logic [9:0]  paddle_y;
    logic [9:0]  paddle_width;
    logic [9:0]  paddle_height;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active_pixels;
    logic [23:0] vga_color;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [1:0]  lives;
    logic        ball_lost;
    logic        game_over;

    always #5 clk = ~clk;

    ball_motion #(
        .BALL_SIZE(8), .TICK_DIV(TD), .SCREEN_W(640), .SCREEN_H(480), .LIVES_INIT(3)
    ) dut (
        .clk(clk), .rst(rst), .launch(launch),
        .paddle_x(paddle_x), .paddle_y(paddle_y),
        .paddle_width(paddle_width), .paddle_height(paddle_height),
        .x(x), .y(y), .active_pixels(active_pixels),
        .vga_color(vga_color), .ball_x(ball_x), .ball_y(ball_y),
        .lives(lives), .ball_lost(ball_lost), .game_over(game_over)
    );

    typedef struct {
        int          bx;
        int          by;
        int          lv;
        bit          lost;
        bit          over;
        logic [23:0] vga;
    } exp_t;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        act;
        logic [23:0] vga;
    } pix_vec_t;

    typedef struct {
        logic [9:0] pad_x;
        logic [9:0] pad_w;
        logic [9:0] pad_y;
        int         bx;
        int         by;
    } serve_vec_t;

    exp_t       exp_q[$];
    pix_vec_t   pix_tbl[8];
    serve_vec_t serve_tbl[4];
    int checks = 0;
    int errors = 0;

    int m_mode, m_cnt, m_bx, m_by, m_dx, m_lives;
    bit m_up, m_armed, m_lost, m_over;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within %0d cycles", name, budget);
    endtask

    // Reference model of one clock edge, written from the behavioural description.
    task automatic model_step();
        bit tick;
        int ox, oy, px, py, pw;
        px = int'(paddle_x);
        py = int'(paddle_y);
        pw = int'(paddle_width);
        if (!rst) begin
            m_mode = M_SERVE; m_cnt = 0; m_dx = 1; m_up = 1; m_armed = 0;
            m_lives = 3; m_lost = 0; m_over = 0;
            m_bx = (px + pw / 2 - 4) & 1023;
            m_by = (py - 8) & 1023;
        end else begin
            tick = (m_cnt == TD);
            m_cnt = tick ? 0 : m_cnt + 1;
            m_lost = 0;
            case (m_mode)
                M_SERVE: begin
                    m_bx = (px + pw / 2 - 4) & 1023;
                    m_by = (py - 8) & 1023;
                    if (launch && m_armed) begin
                        m_mode = M_MOVE; m_dx = 1; m_up = 1; m_armed = 0;
                    end else if (!launch) begin
                        m_armed = 1;
                    end
                end
                M_MOVE: begin
                    if (tick) begin
                        ox = m_bx;
                        oy = m_by;
                        if (m_dx < 0 && ox == 0) m_dx = 1;
                        else if (m_dx > 0 && ox + 8 >= 640) m_dx = -1;
                        else m_bx = ox + m_dx;
                        if (m_up && oy == 0) m_up = 0;
                        else if (!m_up && oy + 8 == py && ox + 8 > px && ox < px + pw) m_up = 1;
                        else if (!m_up && oy + 8 >= 480) begin m_mode = M_LOST; m_lost = 1; end
                        else m_by = m_up ? oy - 1 : oy + 1;
                    end
                end
                M_LOST: begin
                    if (m_lives == 1) begin
                        m_mode = M_OVER;
                        m_over = 1;
                    end else begin
                        m_mode = M_SERVE;
                    end
                    m_lives = m_lives - 1;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: model on the rising edge pushes the expectation, compare on the falling edge.
    task automatic cycle();
        exp_t e;
        exp_t got;
        @(posedge clk);
        model_step();
        e.bx   = m_bx;
        e.by   = m_by;
        e.lv   = m_lives;
        e.lost = m_lost;
        e.over = m_over;
        e.vga  = (active_pixels && int'(x) >= m_bx && int'(x) < m_bx + 8 &&
                  int'(y) >= m_by && int'(y) < m_by + 8) ? 24'hFF0000 : 24'h000000;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check("sb_ball_x", int'(ball_x), got.bx);
        check("sb_ball_y", int'(ball_y), got.by);
        check("sb_lives", int'(lives), got.lv);
        check("sb_ball_lost", int'(ball_lost), int'(got.lost));
        check("sb_game_over", int'(game_over), int'(got.over));
        check("sb_vga_color", int'(vga_color), int'(got.vga));
    endtask

    task automatic serve();
        launch = 1'b0;
        cycle();
        launch = 1'b1;
        cycle();
    endtask

    task automatic wait_y_change(input string name);
        int start, n;
        start = m_by;
        n = 0;
        while (m_by == start && n < LONG) begin cycle(); n++; end
        if (m_by == start) timeout(name, LONG);
    endtask

    task automatic wait_down_at(input string name, input int yv);
        int n;
        n = 0;
        while (!(m_mode == M_MOVE && !m_up && m_by == yv) && n < LONG) begin cycle(); n++; end
        if (!(m_mode == M_MOVE && !m_up && m_by == yv)) timeout(name, LONG);
    endtask

    task automatic wait_mode(input string name, input int mode);
        int n;
        n = 0;
        while (m_mode != mode && n < LONG) begin cycle(); n++; end
        if (m_mode != mode) timeout(name, LONG);
    endtask

    task automatic do_reset(input logic [9:0] px, input logic [9:0] pw, input logic [9:0] py);
        rst = 1'b0;
        paddle_x = px; paddle_width = pw; paddle_y = py;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        int frz_x, frz_y;
        pix_tbl[0] = '{10'd100, 10'd50, 1'b1, 24'hFF0000};
        pix_tbl[1] = '{10'd108, 10'd50, 1'b1, 24'h000000};
        pix_tbl[2] = '{10'd100, 10'd50, 1'b0, 24'h000000};
        pix_tbl[3] = '{10'd107, 10'd57, 1'b1, 24'hFF0000};
        pix_tbl[4] = '{10'd99,  10'd50, 1'b1, 24'h000000};
        pix_tbl[5] = '{10'd100, 10'd58, 1'b1, 24'h000000};
        pix_tbl[6] = '{10'd104, 10'd49, 1'b1, 24'h000000};
        pix_tbl[7] = '{10'd103, 10'd53, 1'b1, 24'hFF0000};
        serve_tbl[0] = '{10'd270, 10'd100, 10'd440, 316, 432};
        serve_tbl[1] = '{10'd600, 10'd72,  10'd440, 632, 432};
        serve_tbl[2] = '{10'd10,  10'd9,   10'd100, 10,  92};
        serve_tbl[3] = '{10'd500, 10'd101, 10'd300, 546, 292};

        rst = 1'b0; launch = 1'b1; paddle_height = 10'd20;
        paddle_x = 10'd270; paddle_width = 10'd100; paddle_y = 10'd440;
        x = 10'd0; y = 10'd0; active_pixels = 1'b0;
        cycle();
        cycle();
        check("rst_ball_x", int'(ball_x), 316);
        check("rst_ball_y", int'(ball_y), 432);
        check("rst_lives", int'(lives), 3);
        check("rst_game_over", int'(game_over), 0);
        rst = 1'b1;

        // Launch held high through reset must not serve; ball keeps tracking.
        for (int i = 0; i < 4; i++) begin
            paddle_x = serve_tbl[i].pad_x; paddle_width = serve_tbl[i].pad_w;
            paddle_y = serve_tbl[i].pad_y;
            repeat (PERIOD) cycle();
            check("serve_track_x", int'(ball_x), serve_tbl[i].bx);
            check("serve_track_y", int'(ball_y), serve_tbl[i].by);
        end
        paddle_x = 10'd270; paddle_width = 10'd100; paddle_y = 10'd440;
        repeat (3 * PERIOD) cycle();
        check("held_launch_y", int'(ball_y), 432);
        serve();
        wait_y_change("first_tick");
        check("first_tick_y", int'(ball_y), 431);
        check("first_tick_x", int'(ball_x), 317);

        // Right wall: direction flips with x held, then x steps back.
        do_reset(10'd600, 10'd72, 10'd440);
        serve();
        wait_y_change("right_wall_1");
        check("right_wall_hold_x", int'(ball_x), 632);
        wait_y_change("right_wall_2");
        check("right_wall_back_x", int'(ball_x), 631);

        // Paddle catch at x=300.
        do_reset(10'd54, 10'd100, 10'd440);
        serve();
        paddle_x = 10'd270;
        wait_down_at("catch_reach", 432);
        check("catch_at_x", int'(ball_x), 300);
        wait_y_change("catch_bounce");
        check("catch_bounce_y", int'(ball_y), 431);

        // x=370 is just past the paddle's right edge: passes through and is lost.
        do_reset(10'd30, 10'd8, 10'd440);
        serve();
        paddle_x = 10'd270; paddle_width = 10'd100;
        wait_down_at("miss_reach", 432);
        check("miss_at_x", int'(ball_x), 370);
        wait_y_change("miss_pass");
        check("miss_pass_y", int'(ball_y), 433);
        wait_mode("miss_lost", M_LOST);
        check("lost_y", int'(ball_y), 472);
        check("lost_pulse", int'(ball_lost), 1);
        check("lost_lives_before", int'(lives), 3);
        cycle();
        check("lost_pulse_end", int'(ball_lost), 0);
        check("lost_lives_after", int'(lives), 2);

        for (int i = 0; i < 2; i++) begin
            paddle_x = 10'd270; paddle_width = 10'd100;
            serve();
            paddle_width = 10'd0;
            wait_mode("lost_again", M_LOST);
            check("lost_again_pulse", int'(ball_lost), 1);
            cycle();
            check("lives_left", int'(lives), 1 - i);
            check("game_over_flag", int'(game_over), i);
        end

        // Game over: ball frozen and launch ignored.
        frz_x = m_bx;
        frz_y = m_by;
        launch = 1'b0;
        repeat (3 * PERIOD) cycle();
        launch = 1'b1;
        repeat (3 * PERIOD) cycle();
        check("over_frozen_x", int'(ball_x), frz_x);
        check("over_frozen_y", int'(ball_y), frz_y);
        check("over_sticky", int'(game_over), 1);

        do_reset(10'd270, 10'd100, 10'd440);
        check("over_rst_game_over", int'(game_over), 0);
        check("over_rst_lives", int'(lives), 3);
        check("over_rst_x", int'(ball_x), 316);

        // Reset in the middle of play.
        serve();
        repeat (10 * PERIOD) cycle();
        do_reset(10'd54, 10'd100, 10'd440);
        check("mid_rst_x", int'(ball_x), 100);
        check("mid_rst_y", int'(ball_y), 432);
        repeat (3 * PERIOD) cycle();
        check("mid_rst_serve_y", int'(ball_y), 432);

        // Pixel colour vectors with the ball parked at (100,50).
        paddle_x = 10'd54; paddle_width = 10'd100; paddle_y = 10'd58;
        cycle();
        for (int i = 0; i < 8; i++) begin
            x = pix_tbl[i].px; y = pix_tbl[i].py; active_pixels = pix_tbl[i].act;
            cycle();
            check("pixel_vec", int'(vga_color), int'(pix_tbl[i].vga));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
